// File: rtl/mem_dump_pkg.sv
// Shared types and default widths for the BRAM dump reader and its output buffer.
package mem_dump_pkg;

  localparam int unsigned MEM_WID      = 1;
  localparam int unsigned MEM_DEPTH    = 8192;
  localparam int unsigned MEM_ADDR_W   = 13;
  localparam int unsigned FIFO_ENTRIES = 4;
  localparam int unsigned FIFO_PTR_W   = 2;
  localparam int unsigned FIFO_CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  typedef struct packed {
    logic [MEM_WID-1:0]    data;
    logic [MEM_ADDR_W-1:0] addr;
    logic                  last;
  } fifo_entry_t;

endpackage

// File: rtl/mem_dump_fifo.sv
// Four-entry synchronous FIFO buffering returned memory words ahead of the output stream.
module mem_dump_fifo
  import mem_dump_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  fifo_entry_t           push_entry,
  input  logic                  pop,
  output fifo_entry_t           head,
  output logic [FIFO_CNT_W-1:0] count
);

  fifo_entry_t           mem_q [FIFO_ENTRIES];
  logic [FIFO_PTR_W-1:0] wptr_q, wptr_d;
  logic [FIFO_PTR_W-1:0] rptr_q, rptr_d;
  logic [FIFO_CNT_W-1:0] count_q, count_d;
  logic                  do_push, do_pop;

  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != FIFO_CNT_W'(FIFO_ENTRIES)) || do_pop);
    wptr_d  = wptr_q + FIFO_PTR_W'(do_push);
    rptr_d  = rptr_q + FIFO_PTR_W'(do_pop);
    count_d = count_q + FIFO_CNT_W'(do_push) - FIFO_CNT_W'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; only slots below count_q are ever presented.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_entry;
  end

  assign head  = mem_q[rptr_q];
  assign count = count_q;

  a_occupancy : assert property (@(posedge clk) disable iff (!reset)
    count_q <= FIFO_CNT_W'(FIFO_ENTRIES));

endmodule

// File: rtl/mem_dump_reader.sv
// Walks an address window of a 1-cycle-latency block memory and streams {data, addr, last}
// beats on a valid/ready interface with backpressure.
module mem_dump_reader
  import mem_dump_pkg::*;
#(
  parameter int unsigned WID_MEM    = MEM_WID,
  parameter int unsigned DEPTH_MEM  = MEM_DEPTH,
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned FIFO_DEPTH = FIFO_ENTRIES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [ADDR_W-1:0]  cfg_base,
  input  logic [ADDR_W:0]    cfg_len,
  output logic [ADDR_W-1:0]  raddr,
  input  logic [WID_MEM-1:0] dout,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WID_MEM-1:0] m_data,
  output logic [ADDR_W-1:0]  m_addr,
  output logic               m_last,
  output logic               busy,
  output logic               done
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  if (WID_MEM != MEM_WID || ADDR_W != MEM_ADDR_W || DEPTH_MEM != (1 << ADDR_W) ||
      FIFO_DEPTH != FIFO_ENTRIES) begin : g_param_check
    $error("mem_dump_reader: unsupported parameter set");
  end

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      issued_q, issued_d;
  logic [CNT_W-1:0]      accepted_q, accepted_d;
  logic [CNT_W-1:0]      len_q, len_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [ADDR_W-1:0]     raddr_q, raddr_d;
  logic                  s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]     s1_addr_q, s1_addr_d;
  logic                  s1_last_q, s1_last_d;
  logic                  done_q, done_d;

  logic                  issue;
  logic                  beat_hs;
  logic                  fifo_valid;
  logic [ADDR_W-1:0]     issue_addr;
  logic [FIFO_CNT_W-1:0] fifo_count;
  fifo_entry_t           push_entry;
  fifo_entry_t           head;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    issued_d   = issued_q;
    accepted_d = accepted_q;
    len_d      = len_q;
    base_d     = base_q;
    done_d     = 1'b0;

    fifo_valid = (fifo_count != '0);
    beat_hs    = fifo_valid && m_ready;
    issue_addr = base_q + issued_q[ADDR_W-1:0];
    // Reads still in the memory pipeline reserve a FIFO slot so the buffer cannot overflow.
    issue      = (state_q == RUN) && (issued_q < len_q) &&
                 ((fifo_count + FIFO_CNT_W'(s1_valid_q)) < FIFO_CNT_W'(FIFO_DEPTH));

    raddr_d    = issue ? issue_addr : raddr_q;
    s1_valid_d = issue;
    s1_addr_d  = issue_addr;
    s1_last_d  = (issued_q == len_q - CNT_W'(1));

    if (issue)   issued_d   = issued_q + CNT_W'(1);
    if (beat_hs) accepted_d = accepted_q + CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RUN;
          base_d     = cfg_base;
          len_d      = (cfg_len == '0) ? CNT_W'(DEPTH_MEM) : cfg_len;
          issued_d   = '0;
          accepted_d = '0;
        end
      end
      RUN: begin
        if (issued_d == len_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (beat_hs && (accepted_q == len_q - CNT_W'(1))) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      accepted_q <= '0;
      len_q      <= '0;
      base_q     <= '0;
      raddr_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_addr_q  <= '0;
      s1_last_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      issued_q   <= issued_d;
      accepted_q <= accepted_d;
      len_q      <= len_d;
      base_q     <= base_d;
      raddr_q    <= raddr_d;
      s1_valid_q <= s1_valid_d;
      s1_addr_q  <= s1_addr_d;
      s1_last_q  <= s1_last_d;
      done_q     <= done_d;
    end
  end

  assign push_entry.data = dout;
  assign push_entry.addr = s1_addr_q;
  assign push_entry.last = s1_last_q;

  mem_dump_fifo u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (s1_valid_q),
    .push_entry (push_entry),
    .pop        (beat_hs),
    .head       (head),
    .count      (fifo_count)
  );

  // Payload is zeroed while idle so stale buffer slots never reach the sink.
  assign raddr   = raddr_d;
  assign m_valid = fifo_valid;
  assign m_data  = fifo_valid ? head.data : '0;
  assign m_addr  = fifo_valid ? head.addr : '0;
  assign m_last  = fifo_valid && head.last;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Randomized bench for mem_dump_reader with a behavioural memory and an expected-beat queue.
module tb_mem_dump_reader;

  localparam int WID   = 1;
  localparam int AW    = 13;
  localparam int DEPTH = 8192;

  typedef struct {
    int addr;
    int data;
    bit last;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [AW-1:0]  cfg_base;
  logic [AW:0]    cfg_len;
  logic [AW-1:0]  raddr;
  logic [WID-1:0] dout;
  logic           m_valid;
  logic           m_ready;
  logic [WID-1:0] m_data;
  logic [AW-1:0]  m_addr;
  logic           m_last;
  logic           busy;
  logic           done;

  logic [WID-1:0] mem [DEPTH];
  logic           mem_load;
  logic           mem_rand;
  logic           we;
  logic [AW-1:0]  waddr;
  logic [WID-1:0] wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_dump_reader dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .cfg_base (cfg_base),
    .cfg_len  (cfg_len),
    .raddr    (raddr),
    .dout     (dout),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_addr   (m_addr),
    .m_last   (m_last),
    .busy     (busy),
    .done     (done)
  );

  // Simple dual-port memory: registered read, read-before-write on address collision.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= mem_rand ? WID'($urandom_range(0, 1)) : WID'(i[0] ^ i[5]);
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
    dout <= mem[raddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic pick_ready(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return (cyc >= 12 && cyc < 22) ? 1'b0 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      default: return ($urandom_range(0, 3) != 0);
    endcase
  endfunction

  task automatic load_mem(input logic rnd);
    @(negedge clk);
    mem_load = 1'b1;
    mem_rand = rnd;
    @(negedge clk);
    mem_load = 1'b0;
  endtask

  // One dump from start to a few idle cycles after done. wr_cycle >= 0 writes addr 7 in that cycle.
  task automatic run_dump(input int base, input int cfg_l, input int mode, input int wr_cycle,
                          input bit poke_start);
    beat_t    exp_q[$];
    beat_t    b;
    int       len, cyc, first_v, last_hs, done_cyc, n_done, n_hs, extra, budget;
    bit       fin, pv_stall;
    logic [AW-1:0]  p_addr;
    logic [WID-1:0] p_data;
    logic           p_last;
    logic [WID-1:0] nv;

    len = (cfg_l == 0) ? DEPTH : cfg_l;
    nv  = ~mem[7];
    for (int i = 0; i < len; i++) begin
      b.addr = (base + i) % DEPTH;
      b.data = int'(mem[b.addr]);
      b.last = (i == len - 1);
      // With m_ready held high, word i is read in cycle i+1; a later-cycle read sees the new value.
      if (wr_cycle >= 0 && b.addr == 7 && (i + 1) > wr_cycle) b.data = int'(nv);
      exp_q.push_back(b);
    end

    budget   = (mode == 0) ? len + 20 : len * 8 + 60;
    first_v  = -1;
    last_hs  = -1;
    done_cyc = -1;
    n_done   = 0;
    n_hs     = 0;
    extra    = 0;
    fin      = 1'b0;
    pv_stall = 1'b0;
    p_addr   = '0;
    p_data   = '0;
    p_last   = 1'b0;

    @(negedge clk);
    start    = 1'b1;
    cfg_base = AW'(base);
    cfg_len  = (AW + 1)'(cfg_l);
    m_ready  = 1'b0;
    cyc      = 0;

    while (!fin) begin
      @(negedge clk);
      cyc++;
      start = poke_start && (cyc == 1);
      if (cyc == 1) begin
        cfg_base = AW'($urandom);
        cfg_len  = (AW + 1)'($urandom_range(1, 300));
        check("busy_run", busy, 1);
      end
      we    = (cyc == wr_cycle);
      waddr = AW'(7);
      wdata = nv;

      if (pv_stall) begin
        check("stall_valid", m_valid, 1);
        check("stall_addr", m_addr, p_addr);
        check("stall_data", m_data, p_data);
        check("stall_last", m_last, p_last);
      end

      m_ready = pick_ready(mode, cyc);
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_beat", n_hs + 1, len);
        end else begin
          b = exp_q.pop_front();
          check("beat_addr", m_addr, b.addr);
          check("beat_data", m_data, b.data);
          check("beat_last", m_last, b.last);
        end
        last_hs = cyc;
        n_hs++;
      end
      pv_stall = m_valid && !m_ready;
      p_addr   = m_addr;
      p_data   = m_data;
      p_last   = m_last;

      if (done) begin
        n_done++;
        if (n_done == 1) done_cyc = cyc;
      end
      if (n_done > 0) begin
        extra++;
        if (extra > 5) fin = 1'b1;
      end
      if (!fin && cyc > budget) begin
        check("timeout_done", n_done, 1);
        fin = 1'b1;
      end
    end

    start   = 1'b0;
    we      = 1'b0;
    m_ready = 1'b0;
    check("beats", n_hs, len);
    check("exp_left", exp_q.size(), 0);
    check("done_once", n_done, 1);
    check("done_after_last", done_cyc, last_hs + 1);
    check("idle_after", busy, 0);
    if (mode == 0) begin
      check("first_valid_cyc", first_v, 3);
      check("last_hs_cyc", last_hs, len + 2);
      check("done_cyc", done_cyc, len + 3);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_m_valid"}, m_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_raddr"}, raddr, 0);
    check({tag, "_m_addr"}, m_addr, 0);
    check({tag, "_m_data"}, m_data, 0);
    check({tag, "_m_last"}, m_last, 0);
  endtask

  task automatic reset_mid();
    int n_hs, cyc, nv, nd;
    n_hs = 0;
    cyc  = 0;
    nv   = 0;
    nd   = 0;
    @(negedge clk);
    start    = 1'b1;
    cfg_base = '0;
    cfg_len  = (AW + 1)'(64);
    m_ready  = 1'b1;
    while (n_hs < 20 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (m_valid && m_ready) n_hs++;
    end
    check("rst_beats_before", n_hs, 20);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_reset_values("rst_mid");
    repeat (20) begin
      @(negedge clk);
      if (m_valid) nv++;
      if (done) nd++;
    end
    check("rst_no_beats", nv, 0);
    check("rst_no_done", nd, 0);
    m_ready = 1'b0;
    run_dump(0, 2, 0, -1, 1'b0);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    cfg_base = '0;
    cfg_len  = '0;
    m_ready  = 1'b0;
    mem_load = 1'b0;
    mem_rand = 1'b0;
    we       = 1'b0;
    waddr    = '0;
    wdata    = '0;
    load_mem(1'b0);
    repeat (2) @(negedge clk);
    check_reset_values("reset");
    reset = 1'b1;

    run_dump(0, 0, 0, -1, 1'b0);
    run_dump(8190, 4, 0, -1, 1'b0);
    run_dump(100, 16, 1, -1, 1'b0);
    run_dump(42, 1, 0, -1, 1'b1);
    reset_mid();
    run_dump(0, 16, 0, 8, 1'b0);
    run_dump(0, 16, 0, int'($urandom_range(4, 12)), 1'b0);

    load_mem(1'b1);
    for (int t = 0; t < 6; t++) begin
      run_dump(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 40)), 2, -1,
               1'b0);
    end
    run_dump(DEPTH - 3, 12, 1, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
